watch_disp_mux: RTL and testbench



---
 rtl/watch_disp_mux.sv | 137 +++++++++++++
 tb/tb_watch_disp_mux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/watch_disp_mux.sv
// watch_disp_mux: time-multiplexes four 7-segment digit patterns onto one
// shared segment bus with one-hot digit enables for a common-cathode module.
// Each digit slot begins with a short blank gap that suppresses ghosting.
// All four digits are latched together at every frame start, which prevents
// tearing. An optional blank suppresses a leading hours zero, and the colon
// blinks at 1 Hz.
module watch_disp_mux #(
    parameter int CLK_HZ       = 32768,
    parameter int SCAN_DIV     = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [6:0] segment_hxxx_i,
    input  logic [6:0] segment_xhxx_i,
    input  logic [6:0] segment_xxmx_i,
    input  logic [6:0] segment_xxxm_i,
    input  logic       en_i,
    input  logic       lzb_i,
    output logic [6:0] seg_o,
    output logic [3:0] dig_o,
    output logic       colon_o
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [CW-1:0] C_LAST  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] C_HALF  = CW'(CLK_HZ / 2);
    localparam logic [6:0]    SEG_ZERO = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [CW-1:0] c_q, c_d;
    logic [6:0]    snap_q [4];
    logic [6:0]    snap_d [4];
    logic          lzb_q, lzb_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          colon_q, colon_d;

    // Next-state for slot/digit/colon counters, frame snapshot and the
    // output values that correspond to the counters registered this edge.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        c_d     = c_q;
        snap_d  = snap_q;
        lzb_d   = lzb_q;
        seg_d   = '0;
        dig_d   = '0;
        colon_d = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            p_d     = '0;
            d_d     = 2'd3;
            c_d     = '0;
        end else begin
            if (state_q == IDLE) begin
                // First enabled edge: counters start from the frame origin.
                p_d = '0;
                d_d = 2'd3;
                c_d = '0;
            end else begin
                if (p_q == P_LAST) begin
                    p_d = '0;
                    d_d = d_q - 2'd1;   // 0 wraps naturally to 3
                end else begin
                    p_d = p_q + 1'b1;
                end
                c_d = (c_q == C_LAST) ? '0 : c_q + 1'b1;
            end

            // Frame start: latch all digits and the blank flag together.
            if ((p_d == '0) && (d_d == 2'd3)) begin
                snap_d[3] = segment_hxxx_i;
                snap_d[2] = segment_xhxx_i;
                snap_d[1] = segment_xxmx_i;
                snap_d[0] = segment_xxxm_i;
                lzb_d     = lzb_i;
            end

            state_d = (p_d < P_BLANK) ? BLANK : SHOW;
            colon_d = (c_d < C_HALF);

            // A leading hours zero keeps the whole d=3 slot dark.
            if ((state_d == SHOW) &&
                !((d_d == 2'd3) && lzb_d && (snap_d[3] == SEG_ZERO))) begin
                dig_d = 4'b0001 << d_d;
                seg_d = snap_d[d_d];
            end
        end
    end

    // State register: synchronous active-low reset, otherwise load next state.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= 2'd3;
            c_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
            end
            lzb_q   <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
            colon_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            c_q     <= c_d;
            snap_q  <= snap_d;
            lzb_q   <= lzb_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            colon_q <= colon_d;
        end
    end

    assign seg_o   = seg_q;
    assign dig_o   = dig_q;
    assign colon_o = colon_q;

endmodule

// File: tb/tb_watch_disp_mux.sv
// Bench for watch_disp_mux: directed phases plus randomized traffic, every
// cycle compared against an arithmetic model of the scan / colon timing.
module tb_watch_disp_mux;

    localparam int CLK_HZ   = 32768;
    localparam int SCAN_DIV = 64;
    localparam int BLANK    = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       lzb;
    logic [6:0] h3, h2, m1, m0;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       colon;

    always #5 clk = ~clk;

    watch_disp_mux #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .segment_hxxx_i(h3),
        .segment_xhxx_i(h2),
        .segment_xxmx_i(m1),
        .segment_xxxm_i(m0),
        .en_i          (en),
        .lzb_i         (lzb),
        .seg_o         (seg),
        .dig_o         (dig),
        .colon_o       (colon)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;          // enabled edges since leaving idle (0 = idle)
    logic [6:0] snap [4];
    logic       snap_lzb = 1'b0;
    logic [6:0] exp_seg;
    logic [3:0] exp_dig;
    logic       exp_colon;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (n=%0d t=%0t)", tag, got, want, n, $time);
        end
    endtask

    // One clock edge: advance the model from the inputs the DUT samples,
    // then compare all outputs just after the edge.
    task automatic tick();
        int   idx;
        int   p;
        int   d;
        logic blank;
        @(posedge clk);
        if (!rstn || !en) begin
            n         = 0;
            exp_seg   = '0;
            exp_dig   = '0;
            exp_colon = 1'b0;
        end else begin
            n++;
            idx = n - 1;
            if (idx % FRAME == 0) begin
                snap[3]  = h3;
                snap[2]  = h2;
                snap[1]  = m1;
                snap[0]  = m0;
                snap_lzb = lzb;
            end
            p     = idx % SCAN_DIV;
            d     = 3 - ((idx / SCAN_DIV) % 4);
            blank = (p < BLANK) || ((d == 3) && snap_lzb && (snap[3] == 7'h3F));
            exp_dig   = blank ? 4'd0 : 4'(1 << d);
            exp_seg   = blank ? 7'd0 : snap[d];
            exp_colon = ((idx % CLK_HZ) < (CLK_HZ / 2));
        end
        #1;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dig", 32'(dig), 32'(exp_dig));
        chk("colon", 32'(colon), 32'(exp_colon));
        chk("onehot", 32'($countones(dig) <= 1), 32'd1);
    endtask

    int   rises;
    logic prev_colon;

    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        lzb  = 1'b0;
        h3 = 7'h06; h2 = 7'h5B; m1 = 7'h4F; m0 = 7'h66;
        for (int i = 0; i < 2; i++) snap[i] = '0;
        for (int i = 2; i < 4; i++) snap[i] = '0;

        // Reset with enable high and inputs toggling.
        for (int i = 0; i < 4; i++) begin
            h3 = 7'($urandom); h2 = 7'($urandom); m1 = 7'($urandom); m0 = 7'($urandom);
            lzb = 1'($urandom);
            tick();
        end
        $display("phase reset: total=%0d bad=%0d", total, bad);
        rstn = 1'b1;

        // Basic scan and snapshot coherency.
        en = 1'b0; tick();
        h3 = 7'h06; h2 = 7'h5B; m1 = 7'h4F; m0 = 7'h66; lzb = 1'b0; en = 1'b1;
        for (int i = 0; i < 520; i++) begin
            tick();
            if (n == 4)   chk("e4_dig", 32'(dig), 32'h0);
            if (n == 5)   begin chk("e5_dig", 32'(dig), 32'h8); chk("e5_seg", 32'(seg), 32'h06); end
            if (n == 64)  chk("e64_dig", 32'(dig), 32'h8);
            if (n == 65)  chk("e65_dig", 32'(dig), 32'h0);
            if (n == 69)  begin chk("e69_dig", 32'(dig), 32'h4); chk("e69_seg", 32'(seg), 32'h5B); end
            if (n == 133) begin chk("e133_dig", 32'(dig), 32'h2); chk("e133_seg", 32'(seg), 32'h4F); end
            if (n == 100) m0 = 7'h6D;
            if (n == 250) begin chk("e250_dig", 32'(dig), 32'h1); chk("e250_seg", 32'(seg), 32'h66); end
            if (n == 261) begin chk("e261_dig", 32'(dig), 32'h8); chk("e261_seg", 32'(seg), 32'h06); end
            if (n == 500) begin chk("e500_dig", 32'(dig), 32'h1); chk("e500_seg", 32'(seg), 32'h6D); end
        end
        $display("phase basic: total=%0d bad=%0d", total, bad);

        // Leading-zero blank, then cleared mid-frame (effective next frame).
        en = 1'b0; tick();
        h3 = 7'h3F; lzb = 1'b1; en = 1'b1;
        for (int i = 0; i < 520; i++) begin
            tick();
            if (n == 10)  begin chk("lzb_dig", 32'(dig), 32'h0); chk("lzb_seg", 32'(seg), 32'h0); end
            if (n == 200) lzb = 1'b0;
            if (n == 300) begin chk("nolzb_dig", 32'(dig), 32'h8); chk("nolzb_seg", 32'(seg), 32'h3F); end
        end
        $display("phase lzb: total=%0d bad=%0d", total, bad);

        // Random traffic with occasional disable and reset.
        for (int i = 0; i < 3000; i++) begin
            h3   = ($urandom_range(0, 3) == 0) ? 7'h3F : 7'($urandom);
            h2   = 7'($urandom);
            m1   = 7'($urandom);
            m0   = 7'($urandom);
            lzb  = 1'($urandom);
            en   = ($urandom_range(0, 299) != 0);
            rstn = ($urandom_range(0, 499) != 0);
            tick();
        end
        rstn = 1'b1;
        $display("phase random: total=%0d bad=%0d", total, bad);

        // Mid-frame disable and restart.
        h3 = 7'h06; h2 = 7'h5B; m1 = 7'h4F; m0 = 7'h66; lzb = 1'b0;
        en = 1'b0; tick();
        en = 1'b1;
        for (int i = 0; i < 200 && n < 150; i++) tick();
        chk("reach150", 32'(n), 32'd150);
        en = 1'b0; tick();
        chk("dis_dig", 32'(dig), 32'h0);
        chk("dis_colon", 32'(colon), 32'h0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("re_dig", 32'(dig), 32'h8);
        chk("re_colon", 32'(colon), 32'h1);
        $display("phase disable: total=%0d bad=%0d", total, bad);

        // Colon over two full seconds.
        en = 1'b0; tick();
        en = 1'b1;
        rises = 0;
        prev_colon = colon;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (colon && !prev_colon) rises++;
            prev_colon = colon;
            if (n == 16384) chk("c16384", 32'(colon), 32'h1);
            if (n == 16385) chk("c16385", 32'(colon), 32'h0);
            if (n == 32768) chk("c32768", 32'(colon), 32'h0);
            if (n == 32769) chk("c32769", 32'(colon), 32'h1);
        end
        chk("colon_rises", 32'(rises), 32'd2);
        $display("phase colon: total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
